// File: rtl/ball_pkg.sv
// Shared sizing, bounce limits and sequencer state encoding for the ball block.
package ball_pkg;
  localparam int NUM_BALLS = 4;
  localparam int BALL_SIZE = 4;
  localparam int H_LIMIT   = 256 - BALL_SIZE;
  localparam int V_LIMIT   = 240 - BALL_SIZE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    H_UPD = 3'd1,
    V_UPD = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/ball_step.sv
// One axis of ball motion: advance pos by move, or bounce (negate move, hold pos) past limit.
module ball_step (
  input  logic [8:0] pos,
  input  logic [8:0] move,
  input  logic [8:0] limit,
  output logic [8:0] new_pos,
  output logic [8:0] new_move
);
  logic [8:0] cand;

  // 9-bit wrap makes a step below zero land >= 256, so it bounces too
  assign cand = pos + move;

  always_comb begin
    new_pos  = cand;
    new_move = move;
    if (cand > limit) begin
      new_pos  = pos;
      new_move = -move;
    end
  end
endmodule

// File: rtl/ball_motion_sched.sv
// Per-frame ball motion sequencer with one shared step unit, config port and hit renderer.
module ball_motion_sched #(
  parameter int NUM_BALLS = ball_pkg::NUM_BALLS,
  parameter int BALL_SIZE = ball_pkg::BALL_SIZE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic       cfg_we,
  input  logic [1:0] cfg_idx,
  input  logic       cfg_en,
  input  logic [8:0] cfg_hpos,
  input  logic [8:0] cfg_vpos,
  input  logic [8:0] cfg_hmove,
  input  logic [8:0] cfg_vmove,
  output logic       cfg_ack,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       ball_gfx,
  output logic [1:0] ball_id
);
  import ball_pkg::*;

  localparam logic [8:0] H_LIM = 9'(256 - BALL_SIZE);
  localparam logic [8:0] V_LIM = 9'(240 - BALL_SIZE);

  logic [NUM_BALLS-1:0][8:0] hpos_q, vpos_q, hmove_q, vmove_q;
  logic [NUM_BALLS-1:0]      en_q;

  state_t     state, state_nx;
  logic [1:0] idx, idx_nx;
  logic       vsync_q, rise, cfg_acc;

  assign rise       = vsync & ~vsync_q;
  assign cfg_acc    = cfg_we & (state == IDLE) & ~rise;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      vsync_q <= 1'b0;
      cfg_ack <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      vsync_q <= vsync;
      cfg_ack <= cfg_acc;
      if (rise && busy) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE:  if (rise) begin state_nx = H_UPD; idx_nx = '0; end
      H_UPD: state_nx = V_UPD;
      V_UPD: state_nx = NEXT;
      NEXT:  begin
        if (idx == 2'(NUM_BALLS - 1)) state_nx = DONE;
        else begin state_nx = H_UPD; idx_nx = idx + 2'd1; end
      end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shared step unit: axis chosen by state, slot by idx
  logic       ax_v;
  logic [8:0] st_pos, st_move, st_lim, st_npos, st_nmove;

  assign ax_v    = (state == V_UPD);
  assign st_pos  = ax_v ? vpos_q[idx]  : hpos_q[idx];
  assign st_move = ax_v ? vmove_q[idx] : hmove_q[idx];
  assign st_lim  = ax_v ? V_LIM : H_LIM;

  ball_step u_step (
    .pos      (st_pos),
    .move     (st_move),
    .limit    (st_lim),
    .new_pos  (st_npos),
    .new_move (st_nmove)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        hpos_q[i]  <= 9'(32 + 64 * i);
        vpos_q[i]  <= 9'd128;
        hmove_q[i] <= (i % 2 == 0) ? 9'd2 : 9'h1FE;
        vmove_q[i] <= 9'd2;
      end
      en_q <= NUM_BALLS'(1);
    end else if (cfg_acc) begin
      en_q[cfg_idx]    <= cfg_en;
      hpos_q[cfg_idx]  <= cfg_hpos;
      vpos_q[cfg_idx]  <= cfg_vpos;
      hmove_q[cfg_idx] <= cfg_hmove;
      vmove_q[cfg_idx] <= cfg_vmove;
    end else if (en_q[idx]) begin
      if (state == H_UPD) begin
        hpos_q[idx]  <= st_npos;
        hmove_q[idx] <= st_nmove;
      end else if (state == V_UPD) begin
        vpos_q[idx]  <= st_npos;
        vmove_q[idx] <= st_nmove;
      end
    end
  end

  // Renderer: unsigned 9-bit offset from each ball's corner, lowest slot wins
  logic [NUM_BALLS-1:0] hit;
  logic [1:0]           hit_id;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_hit
    logic [8:0] dh, dv;
    assign dh     = hpos - hpos_q[g];
    assign dv     = vpos - vpos_q[g];
    assign hit[g] = en_q[g] & (dh < 9'(BALL_SIZE)) & (dv < 9'(BALL_SIZE));
  end

  always_comb begin
    hit_id = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--)
      if (hit[i]) hit_id = 2'(i);
  end

  always_ff @(posedge clk) begin
    if (!reset || !display_on) begin
      ball_gfx <= 1'b0;
      ball_id  <= '0;
    end else begin
      ball_gfx <= |hit;
      ball_id  <= (|hit) ? hit_id : 2'd0;
    end
  end
endmodule

// File: tb/tb_ball_motion_sched.sv
// Bench for ball_motion_sched: directed sequences, render vector table, random vs. frame model.
module tb_ball_motion_sched;
  logic       clk = 1'b0, reset = 1'b0, vsync = 1'b0, display_on = 1'b0;
  logic       cfg_we = 1'b0, cfg_en = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [8:0] hpos = '0, vpos = '0, cfg_hpos = '0, cfg_vpos = '0, cfg_hmove = '0, cfg_vmove = '0;
  logic       cfg_ack, busy, frame_done, overrun, ball_gfx;
  logic [1:0] ball_id;

  ball_motion_sched dut (
    .clk(clk), .reset(reset), .vsync(vsync), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_hpos(cfg_hpos), .cfg_vpos(cfg_vpos), .cfg_hmove(cfg_hmove), .cfg_vmove(cfg_vmove),
    .cfg_ack(cfg_ack), .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .ball_gfx(ball_gfx), .ball_id(ball_id)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_h[4], m_v[4], m_hm[4], m_vm[4];
  bit m_en[4];

  typedef struct {
    int h, v;
    bit don;
    bit gfx;
    int id;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 4; i++) begin
      m_h[i] = 32 + 64 * i; m_v[i] = 128;
      m_hm[i] = (i % 2) ? 510 : 2; m_vm[i] = 2;
      m_en[i] = (i == 0);
    end
  endtask

  task automatic model_axis(inout int pos, inout int mv, input int lim);
    int cand;
    cand = (pos + mv) % 512;
    if (cand > lim) mv = (512 - mv) % 512;
    else pos = cand;
  endtask

  task automatic model_frame;
    for (int i = 0; i < 4; i++)
      if (m_en[i]) begin
        model_axis(m_h[i], m_hm[i], 252);
        model_axis(m_v[i], m_vm[i], 236);
      end
  endtask

  task automatic chk_slots(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s hpos%0d", tag, i), int'(dut.hpos_q[i]), m_h[i]);
      chk($sformatf("%s vpos%0d", tag, i), int'(dut.vpos_q[i]), m_v[i]);
      chk($sformatf("%s hmove%0d", tag, i), int'(dut.hmove_q[i]), m_hm[i]);
      chk($sformatf("%s vmove%0d", tag, i), int'(dut.vmove_q[i]), m_vm[i]);
      chk($sformatf("%s en%0d", tag, i), int'(dut.en_q[i]), int'(m_en[i]));
    end
  endtask

  task automatic do_reset;
    reset = 1'b0; vsync = 1'b0; cfg_we = 1'b0;
    tick; tick;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input int idx, input bit en, input int h, input int v,
                           input int hm, input int vm);
    cfg_idx = 2'(idx); cfg_en = en;
    cfg_hpos = 9'(h); cfg_vpos = 9'(v); cfg_hmove = 9'(hm); cfg_vmove = 9'(vm);
    cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
    chk("cfg_ack pulse", int'(cfg_ack), 1);
    tick;
    chk("cfg_ack drop", int'(cfg_ack), 0);
    m_en[idx] = en; m_h[idx] = h % 512; m_v[idx] = v % 512;
    m_hm[idx] = hm % 512; m_vm[idx] = vm % 512;
  endtask

  task automatic pulse_vsync;
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
  endtask

  // Counts busy and frame_done samples from now until the block is idle again.
  task automatic wait_idle(input string tag, input int exp_busy);
    int nb, nf;
    bit fin;
    nb = 0; nf = 0; fin = 0;
    for (int c = 0; c < 60; c++) begin
      if (busy) nb++;
      if (frame_done) nf++;
      if (!busy) begin fin = 1; break; end
      tick;
    end
    chk({tag, " finished"}, int'(fin), 1);
    chk({tag, " busy cycles"}, nb, exp_busy);
    chk({tag, " frame_done count"}, nf, 1);
  endtask

  task automatic run_frame(input string tag);
    pulse_vsync();
    wait_idle(tag, 13);
    model_frame();
  endtask

  task automatic model_hit(input int h, input int v, input bit don, output bit g, output int id);
    g = 0; id = 0;
    if (don)
      for (int i = 3; i >= 0; i--)
        if (m_en[i] && ((h - m_h[i] + 512) % 512) < 4 && ((v - m_v[i] + 512) % 512) < 4) begin
          g = 1; id = i;
        end
  endtask

  task automatic probe(input string tag, input int h, input int v, input bit don);
    bit g;
    int id;
    hpos = 9'(h); vpos = 9'(v); display_on = don;
    tick;
    model_hit(h, v, don, g, id);
    chk({tag, " ball_gfx"}, int'(ball_gfx), int'(g));
    chk({tag, " ball_id"}, int'(ball_id), id);
  endtask

  initial begin
    int nf;
    // Reset state
    do_reset();
    reset = 1'b0;
    tick;
    chk("rst busy", int'(busy), 0);
    chk("rst frame_done", int'(frame_done), 0);
    chk("rst cfg_ack", int'(cfg_ack), 0);
    chk("rst overrun", int'(overrun), 0);
    chk("rst ball_gfx", int'(ball_gfx), 0);
    chk("rst ball_id", int'(ball_id), 0);
    chk_slots("rst");
    reset = 1'b1;

    // Basic frame: only slot0 enabled
    run_frame("frame1");
    chk("ball0 h after frame", int'(dut.hpos_q[0]), 34);
    chk("ball0 v after frame", int'(dut.vpos_q[0]), 130);
    chk_slots("frame1");
    chk("overrun after clean frame", int'(overrun), 0);

    // Right-edge bounce then move back
    cfg_write(1, 1, 251, 128, 2, 2);
    run_frame("hbounce");
    chk("hmove1 flipped", int'(dut.hmove_q[1]), 9'h1FE);
    chk("hpos1 held", int'(dut.hpos_q[1]), 251);
    run_frame("hback");
    chk("hpos1 returns", int'(dut.hpos_q[1]), 249);
    chk_slots("hback");

    // Top-edge wrap below zero bounces
    cfg_write(0, 1, 50, 1, 2, 9'h1FE);
    run_frame("vbounce");
    chk("vmove0 flipped", int'(dut.vmove_q[0]), 2);
    chk("vpos0 held", int'(dut.vpos_q[0]), 1);
    chk_slots("vbounce");

    // Second vsync edge 5 cycles into a sequence
    pulse_vsync();
    tick; tick; tick;
    pulse_vsync();
    wait_idle("overlap", 9);
    model_frame();
    chk("overrun set", int'(overrun), 1);
    tick; tick;
    chk("no restart after ignored edge", int'(busy), 0);
    chk("overrun sticky", int'(overrun), 1);
    chk_slots("overlap");

    // Write while busy is dropped
    pulse_vsync();
    tick;
    cfg_idx = 2'd3; cfg_en = 1'b1; cfg_hpos = 9'd10; cfg_vpos = 9'd10;
    cfg_hmove = 9'd1; cfg_vmove = 9'd1; cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
    chk("cfg_ack while busy", int'(cfg_ack), 0);
    wait_idle("busywrite", 11);
    model_frame();
    chk_slots("busywrite");

    // Write coincident with the vsync edge is dropped, sequence still starts
    cfg_idx = 2'd2; cfg_en = 1'b1; cfg_hpos = 9'd20; cfg_vpos = 9'd20; cfg_we = 1'b1;
    vsync = 1'b1;
    tick;
    cfg_we = 1'b0; vsync = 1'b0;
    chk("cfg_ack coincident", int'(cfg_ack), 0);
    wait_idle("coincident", 13);
    model_frame();
    chk_slots("coincident");

    // Reset mid-sequence aborts without frame_done
    pulse_vsync();
    tick; tick; tick; tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    model_reset();
    chk("abort busy", int'(busy), 0);
    nf = 0;
    for (int c = 0; c < 16; c++) begin
      if (frame_done) nf++;
      tick;
    end
    chk("abort no frame_done", nf, 0);
    chk("abort overrun cleared", int'(overrun), 0);
    chk_slots("abort");

    // Renderer vector table
    cfg_write(0, 1, 100, 100, 0, 0);
    cfg_write(2, 1, 102, 102, 0, 0);
    cfg_write(3, 1, 200, 50, 0, 0);
    tbl[0] = '{h: 101, v: 101, don: 1, gfx: 1, id: 0};
    tbl[1] = '{h: 101, v: 101, don: 0, gfx: 0, id: 0};
    tbl[2] = '{h: 100, v: 100, don: 1, gfx: 1, id: 0};
    tbl[3] = '{h: 103, v: 103, don: 1, gfx: 1, id: 0};
    tbl[4] = '{h: 104, v: 104, don: 1, gfx: 1, id: 2};
    tbl[5] = '{h: 105, v: 105, don: 1, gfx: 1, id: 2};
    tbl[6] = '{h: 106, v: 106, don: 1, gfx: 0, id: 0};
    tbl[7] = '{h: 99,  v: 101, don: 1, gfx: 0, id: 0};
    tbl[8] = '{h: 201, v: 52,  don: 1, gfx: 1, id: 3};
    tbl[9] = '{h: 203, v: 54,  don: 1, gfx: 0, id: 0};
    for (int k = 0; k < 10; k++) begin
      hpos = 9'(tbl[k].h); vpos = 9'(tbl[k].v); display_on = tbl[k].don;
      tick;
      chk($sformatf("vec%0d ball_gfx", k), int'(ball_gfx), int'(tbl[k].gfx));
      chk($sformatf("vec%0d ball_id", k), int'(ball_id), tbl[k].id);
    end

    // Random mix of writes, frames and beam probes against the model
    for (int it = 0; it < 300; it++) begin
      int r, s, mh, mv;
      r = int'($urandom_range(0, 9));
      if (r <= 2) begin
        mh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                          : (int'($urandom_range(0, 12)) - 6 + 512) % 512;
        mv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                          : (int'($urandom_range(0, 12)) - 6 + 512) % 512;
        cfg_write(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), mh, mv);
      end else if (r <= 4) begin
        run_frame($sformatf("rnd%0d", it));
        chk_slots($sformatf("rnd%0d", it));
      end else begin
        s = int'($urandom_range(0, 3));
        probe($sformatf("rnd%0d", it),
              (m_h[s] + int'($urandom_range(0, 6)) - 1 + 512) % 512,
              (m_v[s] + int'($urandom_range(0, 6)) - 1 + 512) % 512,
              1'($urandom_range(0, 3) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
